// File: rtl/pulse_stretcher_if.sv
// Event-in / stretched-level-out bundle for pulse_stretcher.
// The producer of events is the master; the stretcher is the slave.
interface pulse_stretcher_if #(
  parameter int PEND_W = 4
) ();
  logic              pulse_in;
  logic              overflow_clr;
  logic              level_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (
    output pulse_in, overflow_clr,
    input  level_out, busy, pending, overflow
  );

  modport slave (
    input  pulse_in, overflow_clr,
    output level_out, busy, pending, overflow
  );
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into fixed-length high windows separated by a
// forced low gap; events arriving mid-window are queued and replayed.
module pulse_stretcher #(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int CNT_W       = 16,
  parameter int PEND_W      = 4
) (
  input  logic            clk,
  input  logic            reset,
  pulse_stretcher_if.slave sif
);

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_e;

  localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam bit                HAS_GAP   = (GAP_CYCLES > 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              level_q, level_d;
  logic              busy_q, busy_d;
  logic              launch;
  logic              drop;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    launch  = 1'b0;
    drop    = 1'b0;

    case (state_q)
      IDLE: begin
        if (sif.pulse_in) begin
          state_d = HIGH;
          cnt_d   = HIGH_LOAD;
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          if (HAS_GAP) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            launch = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) launch = 1'b1;
        else             cnt_d  = cnt_q - CNT_W'(1);
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Mid-window events queue up; at saturation they are lost and flagged.
    if (state_q != IDLE && !launch && sif.pulse_in) begin
      if (pend_q != PEND_MAX) pend_d = pend_q + PEND_W'(1);
      else                    drop   = 1'b1;
    end

    // Launch: a queued event wins, a same-cycle event replaces the one consumed.
    if (launch) begin
      if (pend_q != '0) begin
        state_d = HIGH;
        cnt_d   = HIGH_LOAD;
        pend_d  = sif.pulse_in ? pend_q : pend_q - PEND_W'(1);
      end else if (sif.pulse_in) begin
        state_d = HIGH;
        cnt_d   = HIGH_LOAD;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end

    ovf_d   = drop ? 1'b1 : (sif.overflow_clr ? 1'b0 : ovf_q);
    level_d = (state_d == HIGH);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  assign sif.level_out = level_q;
  assign sif.busy      = busy_q;
  assign sif.pending   = pend_q;
  assign sif.overflow  = ovf_q;

endmodule
